// File: rtl/pipe_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   BSH_D_WIDTH / BSH_TAG_WIDTH : default data and tag widths
//   bsh_mode_e                  : operation encodings (SLL, SRL, SRA, ROR)
//   amt_lo()                    : first shift-amount bit resolved by a stage
// Optional feature macro BSH_ROTATE_EN (used by the datapath) is left
// undefined by default; MODE=ROR then behaves as SRL.
package pipe_barrel_shifter_pkg;

   localparam int BSH_D_WIDTH   = 32;
   localparam int BSH_TAG_WIDTH = 5;

   typedef enum logic [1:0] {
      BSH_SLL = 2'b00,
      BSH_SRL = 2'b01,
      BSH_SRA = 2'b10,
      BSH_ROR = 2'b11
   } bsh_mode_e;

   // Amount bit i belongs to stage floor(i*stages/aw); the lowest bit owned by
   // stage s is therefore ceil(s*aw/stages).
   function automatic int amt_lo(input int s, input int stages, input int aw);
      return (s * aw + stages - 1) / stages;
   endfunction

endpackage

// File: rtl/pipe_barrel_shifter_if.sv
// Handshake bundle for pipe_barrel_shifter.
//   master : issue side (drives operation, consumes result)
//   slave  : the shifter itself
// Signals: in_valid/in_ready, mode, sh_amt, d_in, tag_in,
//          out_valid/out_ready, d_out, tag_out.
interface pipe_barrel_shifter_if #(
   parameter int D_WIDTH   = 32,
   parameter int TAG_WIDTH = 5
);
   localparam int AW = $clog2(D_WIDTH);

   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           mode;
   logic [AW-1:0]        sh_amt;
   logic [D_WIDTH-1:0]   d_in;
   logic [TAG_WIDTH-1:0] tag_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [D_WIDTH-1:0]   d_out;
   logic [TAG_WIDTH-1:0] tag_out;

   modport master (
      output in_valid, mode, sh_amt, d_in, tag_in, out_ready,
      input  in_ready, out_valid, d_out, tag_out
   );

   modport slave (
      input  in_valid, mode, sh_amt, d_in, tag_in, out_ready,
      output in_ready, out_valid, d_out, tag_out
   );
endinterface

// File: rtl/pipe_barrel_shifter_bsh_stage.sv
// One pipeline stage of the barrel shifter.
// Resolves amount bits AMT_LO..AMT_HI combinationally on the incoming partial
// result, then registers valid, mode, amount, data, tag and sign when adv=1.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   adv                global advance; stage holds when low
//   in_*  / out_*      valid, mode, amount, data, tag, sign (previous / this stage)
// Macro BSH_ROTATE_EN: when defined, ROR rotates; otherwise ROR acts as SRL.
module bsh_stage
   import pipe_barrel_shifter_pkg::*;
#(
   parameter int D_WIDTH   = BSH_D_WIDTH,
   parameter int TAG_WIDTH = BSH_TAG_WIDTH,
   parameter int AMT_LO    = 0,
   parameter int AMT_HI    = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       adv,
   input  logic                       in_valid,
   input  bsh_mode_e                  in_mode,
   input  logic [$clog2(D_WIDTH)-1:0] in_amt,
   input  logic [D_WIDTH-1:0]         in_data,
   input  logic [TAG_WIDTH-1:0]       in_tag,
   input  logic                       in_sign,
   output logic                       out_valid,
   output bsh_mode_e                  out_mode,
   output logic [$clog2(D_WIDTH)-1:0] out_amt,
   output logic [D_WIDTH-1:0]         out_data,
   output logic [TAG_WIDTH-1:0]       out_tag,
   output logic                       out_sign
);

   logic [D_WIDTH-1:0] data_nxt;

   // Each set amount bit i contributes a shift of 2**i; composing them in
   // sequence gives the full shift. SRA fills from the sign captured at
   // stage 0, never from the partial data.
   always_comb begin
      data_nxt = in_data;
      for (int i = AMT_LO; i <= AMT_HI; i++) begin
         if (in_amt[i]) begin
            case (in_mode)
               BSH_SLL: data_nxt = data_nxt << (1 << i);
               BSH_SRA: data_nxt = (data_nxt >> (1 << i)) |
                                   (in_sign ? ~({D_WIDTH{1'b1}} >> (1 << i)) : '0);
`ifdef BSH_ROTATE_EN
               BSH_ROR: data_nxt = (data_nxt >> (1 << i)) |
                                   (data_nxt << (D_WIDTH - (1 << i)));
`endif
               default: data_nxt = data_nxt >> (1 << i);
            endcase
         end
      end
   end

   // The full amount is carried; later stages only look at their own bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_mode  <= BSH_SLL;
         out_amt   <= '0;
         out_data  <= '0;
         out_tag   <= '0;
         out_sign  <= 1'b0;
      end else if (adv) begin
         out_valid <= in_valid;
         out_mode  <= in_mode;
         out_amt   <= in_amt;
         out_data  <= data_nxt;
         out_tag   <= in_tag;
         out_sign  <= in_sign;
      end
   end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter (SLL / SRL / SRA / optional ROR) with tag sideband.
// Latency is STAGES cycles, throughput one op per cycle; the whole pipe
// advances together when the output is empty or being accepted.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         pipe_barrel_shifter_if.slave (operation in, result out)
// Parameters: D_WIDTH (power of two, >= 8), STAGES (1..log2 D_WIDTH), TAG_WIDTH.
// Macro BSH_ROTATE_EN: enables the rotate datapath for MODE=11.
module pipe_barrel_shifter
   import pipe_barrel_shifter_pkg::*;
#(
   parameter int D_WIDTH   = BSH_D_WIDTH,
   parameter int STAGES    = 2,
   parameter int TAG_WIDTH = BSH_TAG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipe_barrel_shifter_if.slave bus
);

   localparam int AW = $clog2(D_WIDTH);

   logic adv;

   // Index 0 is the input side; index s+1 is the register of stage s.
   logic                 vld  [0:STAGES];
   bsh_mode_e            mode [0:STAGES];
   logic [AW-1:0]        amt  [0:STAGES];
   logic [D_WIDTH-1:0]   data [0:STAGES];
   logic [TAG_WIDTH-1:0] tag  [0:STAGES];
   logic                 sgn  [0:STAGES];

   assign adv          = !vld[STAGES] || bus.out_ready;
   assign bus.in_ready = adv;

   assign vld[0]  = bus.in_valid && adv;
   assign mode[0] = bsh_mode_e'(bus.mode);
   assign amt[0]  = bus.sh_amt;
   assign data[0] = bus.d_in;
   assign tag[0]  = bus.tag_in;
   assign sgn[0]  = bus.d_in[D_WIDTH-1];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      bsh_stage #(
         .D_WIDTH   (D_WIDTH),
         .TAG_WIDTH (TAG_WIDTH),
         .AMT_LO    (amt_lo(s, STAGES, AW)),
         .AMT_HI    (amt_lo(s + 1, STAGES, AW) - 1)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .adv       (adv),
         .in_valid  (vld[s]),
         .in_mode   (mode[s]),
         .in_amt    (amt[s]),
         .in_data   (data[s]),
         .in_tag    (tag[s]),
         .in_sign   (sgn[s]),
         .out_valid (vld[s+1]),
         .out_mode  (mode[s+1]),
         .out_amt   (amt[s+1]),
         .out_data  (data[s+1]),
         .out_tag   (tag[s+1]),
         .out_sign  (sgn[s+1])
      );
   end

   assign bus.out_valid = vld[STAGES];
   assign bus.d_out     = data[STAGES];
   assign bus.tag_out   = tag[STAGES];

   // Control fields of the last stage have no consumer.
   logic unused_tail;
   assign unused_tail = ^{mode[STAGES], amt[STAGES], sgn[STAGES]};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
module tb_pipe_barrel_shifter;
   import pipe_barrel_shifter_pkg::*;

   localparam int DW = 32;
   localparam int TW = 5;
   localparam int ST = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_barrel_shifter_if #(.D_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

   pipe_barrel_shifter #(.D_WIDTH(DW), .STAGES(ST), .TAG_WIDTH(TW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   bit lat_strict = 1'b0;
   bit rand_bp = 1'b0;

   typedef struct {
      logic [DW-1:0] d;
      logic [TW-1:0] tag;
      int            cyc;
   } sb_entry_t;

   sb_entry_t sb[$];
   sb_entry_t e;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] ref_shift(input logic [1:0] m, input int a, input logic [DW-1:0] d);
      case (m)
         2'b00: return d << a;
         2'b10: return DW'($signed(d) >>> a);
`ifdef BSH_ROTATE_EN
         2'b11: return (d >> a) | (d << (DW - a));
`endif
         default: return d >> a;
      endcase
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_out", {63'd0, bus.out_valid}, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_data", {32'd0, bus.d_out}, {32'd0, e.d});
               chk("sb_tag", {59'd0, bus.tag_out}, {59'd0, e.tag});
               if (lat_strict) chk("latency", 64'(cyc - e.cyc), 64'(ST));
            end
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back('{ref_shift(bus.mode, int'(bus.sh_amt), bus.d_in), bus.tag_in, cyc});
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [1:0] m, input logic [4:0] a, input logic [DW-1:0] d,
                       input logic [TW-1:0] t);
      int n;
      bus.in_valid = 1'b1;
      bus.mode     = m;
      bus.sh_amt   = a;
      bus.d_in     = d;
      bus.tag_in   = t;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) chk("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic run_dir(input string name, input logic [1:0] m, input logic [4:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp);
      send(m, a, d, 5'd9);
      @(negedge clk);
      chk({name, "_early"}, {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
      chk(name, {32'd0, bus.d_out}, {32'd0, exp});
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] bp_exp;
   logic [DW-1:0] ror_exp;

   initial begin
      bus.in_valid  = 1'b0;
      bus.mode      = 2'b00;
      bus.sh_amt    = '0;
      bus.d_in      = '0;
      bus.tag_in    = '0;
      bus.out_ready = 1'b1;

      // reset state
      #12;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_d_out", {32'd0, bus.d_out}, 64'd0);
      chk("rst_tag_out", {59'd0, bus.tag_out}, 64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors with exact latency
      lat_strict = 1'b1;
      run_dir("sra_4", 2'b10, 5'd4, 32'h8000_00F0, 32'hF800_000F);
      run_dir("srl_4", 2'b01, 5'd4, 32'h8000_00F0, 32'h0800_000F);
      run_dir("sll_31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
      run_dir("sra_31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
      run_dir("srl_31", 2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
      for (int m = 0; m < 4; m++)
         run_dir("amt0", 2'(m), 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
`ifdef BSH_ROTATE_EN
      ror_exp = 32'h3000_0001;
`else
      ror_exp = 32'h0000_0001;
`endif
      run_dir("mode11_4", 2'b11, 5'd4, 32'h0000_0013, ror_exp);

      // back-to-back, tags 0..7
      for (int t = 0; t < 8; t++)
         send(2'($urandom_range(0, 3)), 5'($urandom), $urandom, 5'(t));
      repeat (ST + 2) @(negedge clk);
      chk("b2b_drained", 64'(sb.size()), 64'd0);
      lat_strict = 1'b0;
      @(posedge clk);
      #1;

      // backpressure: two ops in the pipe, a third waiting at the input
      bus.out_ready = 1'b0;
      send(2'b10, 5'd8, 32'h8123_4567, 5'd20);
      send(2'b00, 5'd3, 32'h0F0F_0F0F, 5'd21);
      bp_exp = ref_shift(2'b10, 8, 32'h8123_4567);
      fork
         send(2'b01, 5'd1, 32'hFFFF_0000, 5'd22);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
               chk("bp_d_out", {32'd0, bus.d_out}, {32'd0, bp_exp});
               chk("bp_tag_out", {59'd0, bus.tag_out}, 64'd20);
               chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      repeat (ST + 3) @(negedge clk);
      chk("bp_drained", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;

      // randomized traffic with random backpressure
      rand_bp = 1'b1;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               logic [4:0] a;
               case ($urandom_range(0, 3))
                  0: a = 5'd0;
                  1: a = 5'd31;
                  default: a = 5'($urandom);
               endcase
               send(2'($urandom_range(0, 3)), a, $urandom, 5'($urandom));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rand_bp = 1'b0;
         end
         begin
            while (rand_bp) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      repeat (ST + 4) @(negedge clk);
      chk("rand_drained", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;

      // reset with two ops in flight
      send(2'b00, 5'd1, 32'h1111_1111, 5'd1);
      send(2'b01, 5'd2, 32'h2222_2222, 5'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("mid_rst_d_out", {32'd0, bus.d_out}, 64'd0);
      chk("mid_rst_tag_out", {59'd0, bus.tag_out}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      sb.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
